dff_chain_ctrl: RTL and testbench

Serializing controller for the 1-bit D flip-flop delay chain in the `npc` datapath. It accepts a parallel word over a valid/ready handshake and drives it LSB-first into the chain input, one bit per clock. It samples the chain output after the chain's fixed latency, reassembles the word, and returns it over a second valid/ready handshake. The chain sits outside this block and is free-running, with no enable; this block owns all sequencing around it.

---
 rtl/dff_chain_ctrl.sv | 119 +++++++++++
 tb/tb_dff_chain_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dff_chain_ctrl.sv
// Serializes a word LSB-first into an external free-running DFF chain and reassembles its output.
// Optional build macro DFF_CHAIN_CHECK_EN adds a returned-vs-sent mismatch flag on err.
module dff_chain_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             err,
    output logic             busy,
    output logic             chain_in,
    input  logic             chain_out
);

    localparam int unsigned Total = WIDTH + DEPTH;
    localparam int unsigned CntW  = $clog2(Total);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  tx_q, tx_d;
    logic [WIDTH-1:0]  rx_q, rx_d;
    logic [WIDTH-1:0]  tx_shift;
    logic              run_last;

    assign run_last = (state_q == StRun) && (cnt_q == CntW'(Total - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        chain_in = 1'b0;
        tx_shift = tx_q >> cnt_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    tx_d    = in_data;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (cnt_q < CntW'(WIDTH)) begin
                    chain_in = tx_shift[0];
                end
                // Bit injected at cnt = i emerges from the chain at cnt = i + DEPTH.
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    if (cnt_q == CntW'(i + DEPTH)) begin
                        rx_d[i] = chain_out;
                    end
                end
                if (run_last) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign out_data  = rx_q;

`ifdef DFF_CHAIN_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (run_last) begin
            err_d = (rx_d != tx_q);
        end else if (state_q == StDone && out_ready) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dff_chain_ctrl.sv
// Bench for dff_chain_ctrl: drives a behavioural DFF chain and checks each word against its
// bit-level expectations (injection order, latency, returned value, err flag).
module tb_dff_chain_ctrl;

    localparam int unsigned W = 8;
    localparam int unsigned D = 4;

`ifdef DFF_CHAIN_CHECK_EN
    localparam bit CheckEn = 1'b1;
`else
    localparam bit CheckEn = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         err;
    logic         busy;
    logic         chain_in;
    logic         chain_out;

    int           vectors     = 0;
    int           miscompares = 0;
    int           cyc         = 0;
    bit           inv_stage2  = 1'b0;
    logic [D-1:0] chain_q     = '0;

    dff_chain_ctrl #(
        .WIDTH(W),
        .DEPTH(D)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .err      (err),
        .busy     (busy),
        .chain_in (chain_in),
        .chain_out(chain_out)
    );

    always #5 clk = ~clk;

    // External chain: D free-running stages, stage 2 optionally inverting.
    always @(posedge clk) begin
        cyc        <= cyc + 1;
        chain_q[0] <= chain_in;
        for (int i = 1; i < D; i++) begin
            chain_q[i] <= (inv_stage2 && i == 1) ? ~chain_q[i-1] : chain_q[i-1];
        end
    end
    assign chain_out = chain_q[D-1];

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of cycle 0 after the accepting edge.
    task automatic accept(input logic [W-1:0] w, input bit keep, input logic [W-1:0] nxt,
                          output int acc);
        int t = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk1("accept_ready", in_ready, 1'b1);
        @(negedge clk);
        acc = cyc;
        if (keep) begin
            in_data = nxt;
        end else begin
            in_valid = 1'b0;
            in_data  = W'($urandom);
        end
    endtask

    // Cycles 0 .. W+D-1 of a transfer, then the first DONE cycle.
    task automatic run_check(input logic [W-1:0] w, input bit keep);
        logic [W-1:0] sh;
        for (int unsigned k = 0; k < W + D; k++) begin
            sh = w >> k;
            chk1("chain_in", chain_in, (k < W) ? sh[0] : 1'b0);
            chk1("out_valid_run", out_valid, 1'b0);
            chk1("in_ready_run", in_ready, 1'b0);
            chk1("busy_run", busy, 1'b1);
            if (!keep) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = W'($urandom);
            end
            @(negedge clk);
        end
        if (!keep) in_valid = 1'b0;
        chk1("out_valid_done", out_valid, 1'b1);
        chkw("out_data", out_data, inv_stage2 ? ~w : w);
        chk1("err_done", err, CheckEn && inv_stage2);
        chk1("chain_in_done", chain_in, 1'b0);
    endtask

    task automatic finish_word(input logic [W-1:0] w, input int stall);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk1("stall_valid", out_valid, 1'b1);
            chkw("stall_data", out_data, inv_stage2 ? ~w : w);
            chk1("stall_in_ready", in_ready, 1'b0);
            chk1("stall_busy", busy, 1'b1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk1("idle_in_ready", in_ready, 1'b1);
        chk1("idle_out_valid", out_valid, 1'b0);
        chk1("idle_busy", busy, 1'b0);
        chk1("idle_err", err, 1'b0);
    endtask

    task automatic xfer(input logic [W-1:0] w, input int stall);
        int acc;
        out_ready = (stall == 0);
        accept(w, 1'b0, '0, acc);
        run_check(w, 1'b0);
        finish_word(w, stall);
    endtask

    initial begin
        int a0, a1, a2;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hFF;
        out_ready = 1'b0;

        repeat (2) begin
            @(negedge clk);
            chk1("rst_in_ready", in_ready, 1'b1);
            chk1("rst_out_valid", out_valid, 1'b0);
            chk1("rst_busy", busy, 1'b0);
            chk1("rst_chain_in", chain_in, 1'b0);
            chkw("rst_out_data", out_data, '0);
            chk1("rst_err", err, 1'b0);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        chk1("post_rst_busy", busy, 1'b0);

        // Single word, consumer ready
        out_ready = 1'b1;
        accept(8'hA5, 1'b0, '0, a0);
        run_check(8'hA5, 1'b0);
        finish_word(8'hA5, 0);

        // Back-pressure
        xfer(8'h3C, 20);

        // Back-to-back with in_valid held
        out_ready = 1'b1;
        accept(8'h01, 1'b1, 8'hFE, a1);
        run_check(8'h01, 1'b1);
        finish_word(8'h01, 0);
        accept(8'hFE, 1'b0, '0, a2);
        chki("b2b_spacing", a2 - a1, W + D + 2);
        run_check(8'hFE, 1'b0);
        finish_word(8'hFE, 0);

        // Mid-run reset at cnt = 6
        out_ready = 1'b1;
        accept(8'hFF, 1'b0, '0, a0);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk1("midrst_in_ready", in_ready, 1'b1);
        chk1("midrst_busy", busy, 1'b0);
        chk1("midrst_chain_in", chain_in, 1'b0);
        chkw("midrst_out_data", out_data, '0);
        rst_n = 1'b1;
        repeat (W + D + 2) begin
            @(negedge clk);
            chk1("midrst_no_valid", out_valid, 1'b0);
        end
        xfer(8'h00, 0);

        // Inverting chain
        inv_stage2 = 1'b1;
        xfer(8'h0F, 0);
        inv_stage2 = 1'b0;

        // Randomized words, stalls and chain polarity
        repeat (10) begin
            inv_stage2 = 1'($urandom_range(0, 1));
            xfer(W'($urandom), int'($urandom_range(0, 3)));
        end
        inv_stage2 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
